tile_fetcher: RTL and testbench

TILE_FETCHER -- requirements
Module: tile_fetcher

---
 rtl/tile_fetcher_if.sv | 20 ++
 rtl/tile_fetcher.sv | 94 +++++++++
 tb/tb_tile_fetcher.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/tile_fetcher_if.sv
// Memory-side bus of the tile fetcher: tile-map and pattern read ports.
// Both memories return data one cycle after their read enable is sampled.
interface tile_fetcher_if;
  logic        tm_ren;
  logic [11:0] tm_raddr;
  logic [5:0]  tm_rdata;
  logic        pat_ren;
  logic [11:0] pat_raddr;
  logic [3:0]  pat_rdata;

  modport master (
    output tm_ren, tm_raddr, pat_ren, pat_raddr,
    input  tm_rdata, pat_rdata
  );

  modport slave (
    input  tm_ren, tm_raddr, pat_ren, pat_raddr,
    output tm_rdata, pat_rdata
  );
endinterface

// File: rtl/tile_fetcher.sv
// Tile-based background renderer: 5-stage fixed-latency pipeline from screen
// coordinates (with wrapping fine scroll) through tile map and pattern memory.
module tile_fetcher (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [9:0]            pix_x,
  input  logic [9:0]            pix_y,
  input  logic                  pix_in_valid,
  input  logic                  frame_start,
  input  logic                  scroll_wr,
  input  logic [5:0]            scroll_wdata,
  tile_fetcher_if.master        mem,
  output logic [3:0]            pix_color,
  output logic                  pix_valid
);

  typedef struct packed {
    logic [2:0] row;
    logic [2:0] col;
    logic       inr;
    logic       vld;
  } side_t;

  logic [5:0]  scroll_pend;
  logic [5:0]  scroll_act;
  logic [5:0]  scroll_use;
  logic [10:0] ex_raw;
  logic [10:0] ey_raw;
  logic [10:0] ex;
  logic [10:0] ey;
  logic        in_range;
  logic [11:0] tile_addr;
  side_t       s1, s2, s3, s4;

  // A write arriving together with frame_start takes effect for this frame.
  always_comb begin
    scroll_use = scroll_act;
    if (frame_start) scroll_use = scroll_wr ? scroll_wdata : scroll_pend;
  end

  always_comb begin
    ex_raw    = {1'b0, pix_x} + 11'(scroll_use[2:0]);
    ey_raw    = {1'b0, pix_y} + 11'(scroll_use[5:3]);
    ex        = (ex_raw >= 11'd640) ? ex_raw - 11'd640 : ex_raw;
    ey        = (ey_raw >= 11'd400) ? ey_raw - 11'd400 : ey_raw;
    in_range  = pix_in_valid && (pix_x < 10'd640) && (pix_y < 10'd400);
    tile_addr = 12'(ey >> 3) * 12'd80 + 12'(ex >> 3);
  end

  // NOTE: all state below uses non-blocking assignments so every stage reads
  // the previous cycle's value of the stage before it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      scroll_pend <= '0;
      scroll_act  <= '0;
    end else begin
      if (scroll_wr)   scroll_pend <= scroll_wdata;
      if (frame_start) scroll_act  <= scroll_use;
    end
  end

  // NOTE: every pipeline register is reset, side-band included, so in-flight
  // pixels are discarded and no stale pix_valid can escape after release.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1            <= '0;
      s2            <= '0;
      s3            <= '0;
      s4            <= '0;
      mem.tm_ren    <= 1'b0;
      mem.tm_raddr  <= '0;
      mem.pat_ren   <= 1'b0;
      mem.pat_raddr <= '0;
      pix_valid     <= 1'b0;
      pix_color     <= '0;
    end else begin
      s1         <= '{row: ey[2:0], col: ex[2:0], inr: in_range, vld: pix_in_valid};
      mem.tm_ren <= in_range;
      if (in_range) mem.tm_raddr <= tile_addr;

      s2 <= s1;

      mem.pat_ren <= s2.inr;
      if (s2.inr) mem.pat_raddr <= {mem.tm_rdata, s2.row, s2.col};
      s3 <= s2;

      s4 <= s3;

      pix_valid <= s4.vld;
      pix_color <= s4.inr ? mem.pat_rdata : 4'd0;
    end
  end

endmodule

// File: tb/tb_tile_fetcher.sv
// Directed bench for tile_fetcher: memory models, a reference colour model and
// a scoreboard queue holding expected colour and due cycle per pixel.
module tb_tile_fetcher;
  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic [9:0] pix_x = '0;
  logic [9:0] pix_y = '0;
  logic       pix_in_valid = 1'b0;
  logic       frame_start = 1'b0;
  logic       scroll_wr = 1'b0;
  logic [5:0] scroll_wdata = '0;
  logic [3:0] pix_color;
  logic       pix_valid;

  tile_fetcher_if mif ();

  tile_fetcher dut (
    .clk          (clk),
    .resetn       (resetn),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .pix_in_valid (pix_in_valid),
    .frame_start  (frame_start),
    .scroll_wr    (scroll_wr),
    .scroll_wdata (scroll_wdata),
    .mem          (mif),
    .pix_color    (pix_color),
    .pix_valid    (pix_valid)
  );

  always #5 clk = ~clk;

  logic [5:0] tile_mem [4096];
  logic [3:0] pat_mem  [4096];

  always @(posedge clk) begin
    if (mif.tm_ren)  mif.tm_rdata  <= tile_mem[mif.tm_raddr];
    if (mif.pat_ren) mif.pat_rdata <= pat_mem[mif.pat_raddr];
  end

  typedef struct {
    int         due;
    logic [3:0] color;
  } exp_t;

  exp_t       sbq[$];
  int         total = 0;
  int         bad = 0;
  int         cycle = 0;
  logic [5:0] m_act = '0;
  logic [5:0] m_pend = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] model_color(int x, int y, int sx, int sy);
    int         ex, ey, ta;
    logic [5:0] t;
    logic [11:0] pa;
    if (x >= 640 || y >= 400) return 4'd0;
    ex = (x + sx) % 640;
    ey = (y + sy) % 400;
    ta = (ey / 8) * 80 + ex / 8;
    t  = tile_mem[ta];
    pa = {t, 3'(ey % 8), 3'(ex % 8)};
    return pat_mem[pa];
  endfunction

  // One clock: drive inputs, take the edge, then score the output side.
  task automatic step(input logic v, input int x, input int y,
                      input logic fs, input logic wr, input logic [5:0] wd);
    logic [5:0] use_s;
    logic       exp_v;
    exp_t       e;
    pix_in_valid = v;
    pix_x        = 10'(x);
    pix_y        = 10'(y);
    frame_start  = fs;
    scroll_wr    = wr;
    scroll_wdata = wd;
    use_s = fs ? (wr ? wd : m_pend) : m_act;
    @(posedge clk);
    cycle++;
    if (resetn) begin
      if (v) sbq.push_back('{due: cycle + 4,
                             color: model_color(x, y, int'(use_s[2:0]), int'(use_s[5:3]))});
      if (wr) m_pend = wd;
      if (fs) m_act = use_s;
    end
    #1;
    exp_v = (sbq.size() > 0) && (sbq[0].due == cycle);
    check("pix_valid", {31'd0, pix_valid}, {31'd0, exp_v});
    if (exp_v) begin
      e = sbq.pop_front();
      check("pix_color", {28'd0, pix_color}, {28'd0, e.color});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0, 1'b0, 6'd0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      tile_mem[i] = 6'((i * 37 + 11) % 64);
      pat_mem[i]  = 4'((i * 13 + i / 64) % 16);
    end
    tile_mem[82]    = 6'd5;
    pat_mem[12'h149] = 4'hA;
    mif.tm_rdata  = '0;
    mif.pat_rdata = '0;

    // Asynchronous reset before any clock edge
    #2 resetn = 1'b0;
    #1;
    check("rst_tm_ren",    {31'd0, mif.tm_ren},   32'd0);
    check("rst_pat_ren",   {31'd0, mif.pat_ren},  32'd0);
    check("rst_pix_valid", {31'd0, pix_valid},    32'd0);
    check("rst_pix_color", {28'd0, pix_color},    32'd0);
    check("rst_tm_raddr",  {20'd0, mif.tm_raddr}, 32'd0);
    check("rst_pat_raddr", {20'd0, mif.pat_raddr}, 32'd0);
    idle(2);
    resetn = 1'b1;
    idle(2);

    // Basic fetch at scroll 0: (17,9) -> tile 82 -> pattern 0x149 -> colour A
    step(1'b1, 17, 9, 1'b0, 1'b0, 6'd0);
    check("b_tm_ren", {31'd0, mif.tm_ren}, 32'd1);
    check("b_tm_raddr", {20'd0, mif.tm_raddr}, 32'd82);
    idle(1);
    check("b_tm_ren_drop", {31'd0, mif.tm_ren}, 32'd0);
    check("b_tm_raddr_hold", {20'd0, mif.tm_raddr}, 32'd82);
    idle(1);
    check("b_pat_ren", {31'd0, mif.pat_ren}, 32'd1);
    check("b_pat_raddr", {20'd0, mif.pat_raddr}, 32'h149);
    idle(2);

    // Wrap in both axes with scroll x=3, y=2 applied on frame_start
    step(1'b0, 0, 0, 1'b1, 1'b1, 6'b010_011);
    step(1'b1, 639, 399, 1'b0, 1'b0, 6'd0);
    check("w_tm_ren", {31'd0, mif.tm_ren}, 32'd1);
    check("w_tm_raddr", {20'd0, mif.tm_raddr}, 32'd0);
    idle(2);
    check("w_pat_low", {26'd0, mif.pat_raddr[5:0]}, 32'b001_010);
    check("w_pat_raddr", {20'd0, mif.pat_raddr}, 32'(int'(tile_mem[0]) * 64 + 10));
    idle(2);

    // Out-of-range pixel: no reads, addresses held, colour 0 still valid
    step(1'b1, 700, 5, 1'b0, 1'b0, 6'd0);
    check("o_tm_ren", {31'd0, mif.tm_ren}, 32'd0);
    check("o_tm_raddr_hold", {20'd0, mif.tm_raddr}, 32'd0);
    idle(2);
    check("o_pat_ren", {31'd0, mif.pat_ren}, 32'd0);
    check("o_pat_raddr_hold", {20'd0, mif.pat_raddr}, 32'(int'(tile_mem[0]) * 64 + 10));
    idle(2);

    // Pending scroll waits for frame_start
    step(1'b0, 0, 0, 1'b0, 1'b1, 6'h3F);
    step(1'b1, 10, 10, 1'b0, 1'b0, 6'd0);
    check("s_old_scroll", {20'd0, mif.tm_raddr}, 32'd81);
    step(1'b0, 0, 0, 1'b1, 1'b0, 6'd0);
    step(1'b1, 10, 10, 1'b0, 1'b0, 6'd0);
    check("s_new_scroll", {20'd0, mif.tm_raddr}, 32'd162);
    // Last write of the frame wins
    step(1'b0, 0, 0, 1'b0, 1'b1, 6'b000_001);
    step(1'b0, 0, 0, 1'b0, 1'b1, 6'b010_010);
    step(1'b0, 0, 0, 1'b1, 1'b0, 6'd0);
    step(1'b1, 6, 6, 1'b0, 1'b0, 6'd0);
    check("s_last_wins", {20'd0, mif.tm_raddr}, 32'd81);
    // Write together with frame_start applies immediately
    step(1'b0, 0, 0, 1'b1, 1'b1, 6'd0);
    step(1'b1, 6, 6, 1'b0, 1'b0, 6'd0);
    check("s_same_cycle", {20'd0, mif.tm_raddr}, 32'd0);
    // Scroll change right behind a pixel must not alter it
    step(1'b1, 100, 50, 1'b0, 1'b0, 6'd0);
    step(1'b0, 0, 0, 1'b1, 1'b1, 6'h3F);
    idle(4);

    // Full 640-pixel line at scroll 7/7, wrapping at the right edge
    for (int x = 0; x < 640; x++) step(1'b1, x, 20, 1'b0, 1'b0, 6'd0);
    idle(5);

    // Reset with the pipeline full
    for (int x = 1; x <= 4; x++) step(1'b1, x, 1, 1'b0, 1'b0, 6'd0);
    resetn = 1'b0;
    #1;
    check("r_tm_ren",    {31'd0, mif.tm_ren},   32'd0);
    check("r_pat_ren",   {31'd0, mif.pat_ren},  32'd0);
    check("r_pix_valid", {31'd0, pix_valid},    32'd0);
    check("r_pix_color", {28'd0, pix_color},    32'd0);
    check("r_tm_raddr",  {20'd0, mif.tm_raddr}, 32'd0);
    check("r_pat_raddr", {20'd0, mif.pat_raddr}, 32'd0);
    sbq.delete();
    m_act  = '0;
    m_pend = '0;
    idle(2);
    resetn = 1'b1;
    idle(4);
    step(1'b1, 16, 8, 1'b0, 1'b0, 6'd0);
    check("r_post_tm_raddr", {20'd0, mif.tm_raddr}, 32'd82);
    idle(6);

    check("sb_empty", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
